if_fetch_ctrl: RTL
==================

# if_fetch_ctrl

Instruction-fetch controller placed directly downstream of the PC register. It consumes `pc`/`ce` and issues one instruction read per PC over the SRAM-like instruction port that feeds the AXI bridge. It returns the fetched word to the IF/ID register and holds the PC with `stallreq_if` until that word is available. It also maps kseg0/kseg1 addresses to physical addresses, flags misaligned fetches, and drains transactions that are cut short by a flush.

## Interface
Parameters:
- `RESET_INST`, 32'h0000_0000, value driven on `inst_o` when no valid word is present.

Ports:
- `clk` in 1: the single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 6: pipeline stall vector; `stall[1]` high means IF/ID will not capture this cycle.
- `flush` in 1: exception/eret flush; the PC register loads `new_pc` on the next edge.
- `pc` in 32: current fetch address from the PC register.
- `ce` in 1: fetch enable from the PC register (low during and just after reset).
- `inst_req` out 1: request valid on the instruction port.
- `inst_addr` out 32: physical request address.
- `inst_addr_ok` in 1: request accepted this cycle.
- `inst_data_ok` in 1: read data valid this cycle; returned in request order.
- `inst_rdata` in 32: read data.
- `inst_o` out 32: instruction word to IF/ID.
- `adel_o` out 1: fetch address error (pc[1:0] != 0) to IF/ID.
- `stallreq_if` out 1: stall request to the control unit.

## Operation
- **States:** IDLE (nothing outstanding), REQ (request pending, address latched), WAIT (accepted, awaiting data), HOLD (data buffered, pipeline stalled).
- **Internal registers:** `addr_q` [31:0], `buf_q` [31:0], `drop_q` (the response for the transaction in flight must be discarded).
- **Address mapping:**
  - If pc[31:30]==2'b10 (kseg0/kseg1): `inst_addr` = {3'b000, pc[28:0]}.
  - Otherwise: `inst_addr` = pc.
  - Example: 0xBFC00000 -> 0x1FC00000.
- **adel:** `adel_o` = ce & (pc[1:0]!=0). When adel is set:
  - no request is issued;
  - `inst_o` = RESET_INST;
  - `stallreq_if` = 0, so the exception proceeds down the pipeline.
- **IDLE:**
  - `inst_req` = ce & !adel & !flush; `inst_addr` = mapped pc (combinational).
  - If addr_ok: go to WAIT.
  - Else if `inst_req`: latch the mapped pc into `addr_q` and go to REQ.
- **REQ:**
  - `inst_req` = 1 and `inst_addr` = `addr_q`. Both are held until addr_ok; flush does not withdraw the request.
  - On addr_ok: go to WAIT.
- **WAIT:**
  - `inst_req` = 0.
  - On data_ok with `drop_q`=1: discard the data, clear `drop_q`, go to IDLE.
  - On data_ok with `drop_q`=0: drive `inst_o` = `inst_rdata` (bypass).
    - If `stall[1]`=0: go to IDLE.
    - If `stall[1]`=1: `buf_q` <= `inst_rdata`, go to HOLD.
- **HOLD:**
  - `inst_o` = `buf_q`; no request is issued.
  - When `stall[1]`=0: go to IDLE.
  - Flush: go to IDLE and discard `buf_q`.
- **Flush in REQ or WAIT:** set `drop_q`. The state machine continues the transaction to completion, then refetches from the new pc in IDLE.
- **stallreq_if:**
  - 1 when ce & !flush & !adel and the word for the current pc is not being presented this cycle. This covers: IDLE issuing, REQ, WAIT without valid data, and any cycle with `drop_q`=1.
  - 0 in HOLD, in WAIT with data_ok & !`drop_q`, and whenever ce=0.
- **At most one outstanding transaction.** A new request is never issued while in REQ/WAIT/HOLD.

## Timing
- **Reset** (rst=1 at posedge): state=IDLE, `drop_q`=0, `buf_q`=RESET_INST, `addr_q`=0. While rst=1, outputs are forced: `inst_req`=0, `inst_o`=RESET_INST, `adel_o`=0, `stallreq_if`=0.
- **Reset mid-transaction:** in-flight state is abandoned; the bridge is reset by the same rst.
- **Best-case latency:** req and addr_ok in cycle N, data_ok in cycle N+1. `inst_o` is valid and `stallreq_if`=0 in N+1; the PC advances at the end of N+1.
- **Throughput:** one fetch per two cycles when addr_ok/data_ok are single-cycle. The next request is issued in IDLE the cycle after delivery.
- **Simultaneous events:**
  - flush together with data_ok & !`drop_q`: the data is discarded; `inst_o` shows it, but IF/ID is flushed.
  - flush together with addr_ok in IDLE: no request (`inst_req` is gated by flush).
  - data_ok together with `stall[1]` falling: deliver and go to IDLE; HOLD is not entered.
- The `ce` rising edge after reset starts the first fetch in the same cycle.

## Test plan
- **Reset then boot fetch:** rst held 3 cycles then released, ce rises, pc=0xBFC00000, addr_ok immediate, data_ok next cycle with 0x3C08BFC0 -> `inst_addr`=0x1FC00000; `stallreq_if` = 1 then 0; `inst_o`=0x3C08BFC0 in the data cycle.
- **Slow slave:** addr_ok delayed 3 cycles, then data_ok delayed 2 -> `inst_addr` stays stable (latched) through REQ; `stallreq_if`=1 for every cycle until data_ok; exactly one request is accepted.
- **Downstream stall:** `stall[1]`=1 when data_ok returns 0x24020001 -> HOLD; `inst_o`=0x24020001 while stalled; no new `inst_req`; IDLE one cycle after `stall[1]` falls.
- **Flush during WAIT:** flush while awaiting data; pc becomes 0xBFC00380 -> stale data dropped; the next accepted request has address 0x1FC00380; `stallreq_if` remains 1 until that new data arrives.
- **Misaligned pc:** pc=0x80000002 -> `adel_o`=1, `inst_req`=0, `stallreq_if`=0, `inst_o`=RESET_INST.
- **kuseg pass-through:** pc=0x00400000 -> `inst_addr`=0x00400000.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: issues one SRAM-like read per PC, returns the
// word to IF/ID, stalls the PC until the word is present, maps kseg0/kseg1,
// flags misaligned fetches and drains transactions cut short by a flush.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] pc,
    input  logic        ce,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] inst_o,
    output logic        adel_o,
    output logic        stallreq_if
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] buf_q, buf_d;
    logic        drop_q, drop_d;

    logic [31:0] mapped_addr;
    logic        adel;
    logic        fetch_en;
    logic        unused_stall;

    // Only IF/ID's stall bit matters to the fetch stage.
    assign unused_stall = ^{stall[5:2], stall[0]};

    // kseg0/kseg1 drop the top three bits; everything else passes through.
    assign mapped_addr = (pc[31:30] == 2'b10) ? {3'b000, pc[28:0]} : pc;
    assign adel        = ce & (pc[1:0] != 2'b00);
    assign fetch_en    = ce & ~flush & ~adel;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= 32'h0000_0000;
            buf_q   <= RESET_INST;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        buf_d       = buf_q;
        drop_d      = drop_q;
        inst_req    = 1'b0;
        inst_addr   = mapped_addr;
        inst_o      = RESET_INST;
        stallreq_if = 1'b0;
        adel_o      = adel;

        unique case (state_q)
            S_IDLE: begin
                inst_req    = fetch_en;
                stallreq_if = fetch_en;
                if (fetch_en) begin
                    if (inst_addr_ok) begin
                        state_d = S_WAIT;
                    end else begin
                        addr_d  = mapped_addr;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // Request stays up even across a flush; its response is dropped later.
                inst_req    = 1'b1;
                inst_addr   = addr_q;
                stallreq_if = fetch_en;
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (inst_addr_ok) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                stallreq_if = fetch_en & ~(inst_data_ok & ~drop_q);
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (inst_data_ok) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        // Data for the current pc completes the transaction, so nothing to drop.
                        inst_o = inst_rdata;
                        drop_d = 1'b0;
                        if (flush || !stall[1]) begin
                            state_d = S_IDLE;
                        end else begin
                            buf_d   = inst_rdata;
                            state_d = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                inst_o = buf_q;
                if (flush) begin
                    buf_d   = RESET_INST;
                    state_d = S_IDLE;
                end else if (!stall[1]) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Misaligned fetch: no word, no stall, let the exception travel.
        if (adel) begin
            inst_o      = RESET_INST;
            stallreq_if = 1'b0;
        end

        if (rst) begin
            inst_req    = 1'b0;
            inst_o      = RESET_INST;
            adel_o      = 1'b0;
            stallreq_if = 1'b0;
        end
    end

endmodule
